// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single-port DataMemory between the CPU data port (m0) and a
// secondary master (m1). One access is granted per cycle. m0 has fixed
// priority, but once m1 has been denied MAX_WAIT consecutive cycles it wins
// the next cycle. Read data comes back one cycle after the grant and is
// flagged with an rvalid to whichever requester issued the read.
//
// Parameters
//   ALEN      address width
//   XLEN      data width
//   MAX_WAIT  consecutive denied m1 cycles before m1 overrides m0 (1..255)
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   m{0,1}_req/we/be/funct3/addr/wdata   requester command, held until gnt
//   m{0,1}_gnt                 combinational accept for this cycle
//   m{0,1}_rvalid/rdata        read response (rdata is unqualified)
//   mem_we/be/funct3/addr/wdata  command to DataMemory
//   mem_rdata                  DataMemory read data, one cycle after the read
//   m1_starved                 registered, high while m1 is at its wait limit
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ALEN     = 32,
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            m0_req,
    input  logic            m0_we,
    input  logic [3:0]      m0_be,
    input  logic [2:0]      m0_funct3,
    input  logic [ALEN-1:0] m0_addr,
    input  logic [XLEN-1:0] m0_wdata,
    output logic            m0_gnt,
    output logic            m0_rvalid,
    output logic [XLEN-1:0] m0_rdata,

    input  logic            m1_req,
    input  logic            m1_we,
    input  logic [3:0]      m1_be,
    input  logic [2:0]      m1_funct3,
    input  logic [ALEN-1:0] m1_addr,
    input  logic [XLEN-1:0] m1_wdata,
    output logic            m1_gnt,
    output logic            m1_rvalid,
    output logic [XLEN-1:0] m1_rdata,

    output logic            mem_we,
    output logic [3:0]      mem_be,
    output logic [2:0]      mem_funct3,
    output logic [ALEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,

    output logic            m1_starved
);

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    logic [7:0] wait_cnt;
    logic [7:0] wait_nxt;
    logic       rd_pend;
    logic       rd_owner;   // 0 = m0, 1 = m1
    logic       force_m1;
    logic       gnt0;
    logic       gnt1;
    logic       rd_grant;

    // ------------------------------------------------------------------
    // Grant decision: m1 overrides m0 only once it has hit its wait limit.
    // ------------------------------------------------------------------
    assign force_m1 = m1_req && (wait_cnt == WAIT_LIMIT);
    assign gnt1     = force_m1 || (m1_req && !m0_req);
    assign gnt0     = m0_req && !force_m1;

    assign m0_gnt   = gnt0;
    assign m1_gnt   = gnt1;

    // ------------------------------------------------------------------
    // Memory command mux. With no grant the command is a harmless no-op;
    // the address/data side simply follows m0.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        mem_we     = 1'b0;
        mem_be     = 4'h0;
        mem_funct3 = m0_funct3;
        mem_addr   = m0_addr;
        mem_wdata  = m0_wdata;
        if (gnt1) begin
            mem_we     = m1_we;
            mem_be     = m1_be;
            mem_funct3 = m1_funct3;
            mem_addr   = m1_addr;
            mem_wdata  = m1_wdata;
        end else if (gnt0) begin
            mem_we     = m0_we;
            mem_be     = m0_be;
            mem_funct3 = m0_funct3;
            mem_addr   = m0_addr;
            mem_wdata  = m0_wdata;
        end
        // No memory writes can slip through while the system is in reset.
        if (!rst_n) begin
            mem_we = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Starvation counter: counts consecutive denied m1 cycles, saturating
    // at the limit. Any grant or a dropped request starts over from zero.
    // ------------------------------------------------------------------
    always_comb begin
        wait_nxt = 8'd0;
        if (m1_req && !gnt1) begin
            wait_nxt = (wait_cnt == WAIT_LIMIT) ? wait_cnt : wait_cnt + 8'd1;
        end
    end

    assign rd_grant = (gnt0 && !m0_we) || (gnt1 && !m1_we);

    // ------------------------------------------------------------------
    // State: wait counter, starvation flag, and the one-deep read tracker
    // that remembers who owns the data arriving next cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt   <= 8'd0;
            m1_starved <= 1'b0;
            rd_pend    <= 1'b0;
            rd_owner   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            wait_cnt   <= wait_nxt;
            m1_starved <= (wait_nxt == WAIT_LIMIT);
            rd_pend    <= rd_grant;
            rd_owner   <= rd_grant && gnt1;
        end
    end

    // ------------------------------------------------------------------
    // Response routing: data is broadcast, rvalid picks the owner.
    // ------------------------------------------------------------------
    assign m0_rvalid = rd_pend && !rd_owner;
    assign m1_rvalid = rd_pend &&  rd_owner;
    assign m0_rdata  = mem_rdata;
    assign m1_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Self-checking bench for dmem_arbiter. A reference process models the
// arbitration rules (denied-cycle count, pending read owner) together with a
// small word-addressed DataMemory, and compares every DUT output on each
// falling edge. Directed sequences with literal expectations come first,
// followed by randomized traffic that honours the hold-until-grant protocol.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int ALEN     = 32;
    localparam int XLEN     = 32;
    localparam int MAX_WAIT = 8;

    logic            clk;
    logic            rst_n;
    logic            m0_req, m0_we, m1_req, m1_we;
    logic [3:0]      m0_be, m1_be;
    logic [2:0]      m0_funct3, m1_funct3;
    logic [ALEN-1:0] m0_addr, m1_addr;
    logic [XLEN-1:0] m0_wdata, m1_wdata;
    logic            m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [XLEN-1:0] m0_rdata, m1_rdata;
    logic            mem_we;
    logic [3:0]      mem_be;
    logic [2:0]      mem_funct3;
    logic [ALEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;
    logic            m1_starved;

    dmem_arbiter #(.ALEN(ALEN), .XLEN(XLEN), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_funct3(m0_funct3),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_funct3(m1_funct3),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_we(mem_we), .mem_be(mem_be), .mem_funct3(mem_funct3),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .m1_starved(m1_starved)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Environment memory (64 words) and grants the model predicted last cycle.
    logic [31:0] mem [64];
    bit          last_g0, last_g1;

    // ------------------------------------------------------------------
    // Reference model + compare, one pass per cycle.
    // ------------------------------------------------------------------
    initial begin : model
        int          deny;
        bit          pend, owner;
        logic [31:0] pend_data;
        bit          e0, e1;
        logic        x_we;
        logic [3:0]  x_be;
        logic [2:0]  x_f3;
        logic [31:0] x_addr, x_wdata;
        int          n_deny;
        bit          n_pend, n_owner;
        logic [31:0] n_data;
        bit          w_en;
        int          w_idx;
        logic [31:0] w_data;
        logic [3:0]  w_be;
        deny = 0; pend = 0; owner = 0; pend_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                deny = 0; pend = 0; owner = 0;
            end
            // Grant rule: m1 wins when it has waited out its limit or m0 is idle.
            e1 = m1_req && (deny >= MAX_WAIT || !m0_req);
            e0 = m0_req && !e1;
            if (e1) begin
                x_we = m1_we; x_be = m1_be; x_f3 = m1_funct3; x_addr = m1_addr; x_wdata = m1_wdata;
            end else if (e0) begin
                x_we = m0_we; x_be = m0_be; x_f3 = m0_funct3; x_addr = m0_addr; x_wdata = m0_wdata;
            end else begin
                x_we = 1'b0; x_be = 4'h0; x_f3 = m0_funct3; x_addr = m0_addr; x_wdata = m0_wdata;
            end
            if (!rst_n) x_we = 1'b0;

            check("m0_gnt", 32'(m0_gnt), 32'(e0));
            check("m1_gnt", 32'(m1_gnt), 32'(e1));
            check("mem_we", 32'(mem_we), 32'(x_we));
            check("mem_be", 32'(mem_be), 32'(x_be));
            check("mem_funct3", 32'(mem_funct3), 32'(x_f3));
            check("mem_addr", mem_addr, x_addr);
            check("mem_wdata", mem_wdata, x_wdata);
            check("m0_rvalid", 32'(m0_rvalid), 32'(pend && !owner));
            check("m1_rvalid", 32'(m1_rvalid), 32'(pend && owner));
            check("m0_rdata_pass", m0_rdata, mem_rdata);
            check("m1_rdata_pass", m1_rdata, mem_rdata);
            if (pend && !owner) check("m0_rdata", m0_rdata, pend_data);
            if (pend && owner)  check("m1_rdata", m1_rdata, pend_data);
            check("m1_starved", 32'(m1_starved), 32'(deny == MAX_WAIT));

            n_deny  = (m1_req && !e1) ? ((deny + 1 > MAX_WAIT) ? MAX_WAIT : deny + 1) : 0;
            n_pend  = (e0 || e1) && !x_we && rst_n;
            n_owner = n_pend && e1;
            n_data  = mem[x_addr[7:2]];
            w_en    = (e0 || e1) && x_we;
            w_idx   = int'(x_addr[7:2]);
            w_data  = x_wdata;
            w_be    = x_be;
            last_g0 = e0;
            last_g1 = e1;

            @(posedge clk);
            if (rst_n) begin
                deny = n_deny; pend = n_pend; owner = n_owner; pend_data = n_data;
                if (w_en) begin
                    for (int b = 0; b < 4; b++)
                        if (w_be[b]) mem[w_idx][8*b +: 8] = w_data[8*b +: 8];
                end
            end else begin
                deny = 0; pend = 0; owner = 0;
            end
            #1 mem_rdata = n_pend ? n_data : $urandom;
        end
    end

    task automatic set_m0(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        m0_req = r; m0_we = w; m0_addr = a; m0_wdata = d; m0_be = 4'hF; m0_funct3 = 3'b010;
    endtask

    task automatic set_m1(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        m1_req = r; m1_we = w; m1_addr = a; m1_wdata = d; m1_be = 4'hF; m1_funct3 = 3'b010;
    endtask

    // ------------------------------------------------------------------
    // Stimulus: directed sequences with literal expectations, then random.
    // ------------------------------------------------------------------
    initial begin : driver
        logic [31:0] b2b_exp [3];
        int          m0_rate;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h1111_0000;
        mem[1] = 32'h2222_0004;
        mem[2] = 32'h3333_0008;
        mem[4] = 32'h1234_5678;
        mem_rdata = '0;
        rst_n = 1'b0;
        set_m0(1'b1, 1'b0, 32'h10, 32'h0);
        set_m1(1'b0, 1'b0, 32'h0, 32'h0);

        // Reset: combinational path live, writes blocked, no responses.
        repeat (2) @(negedge clk);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
        check("rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
        check("rst_starved", 32'(m1_starved), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("first_m0_gnt", 32'(m0_gnt), 32'd1);
        @(posedge clk); #1 set_m0(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("first_m0_rvalid", 32'(m0_rvalid), 32'd1);
        check("first_m1_rvalid", 32'(m1_rvalid), 32'd0);
        check("first_m0_rdata", m0_rdata, 32'h1234_5678);

        // Single m1 write.
        @(posedge clk); #1 set_m1(1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF);
        @(negedge clk);
        check("wr_m1_gnt", 32'(m1_gnt), 32'd1);
        check("wr_mem_we", 32'(mem_we), 32'd1);
        check("wr_mem_addr", mem_addr, 32'h20);
        check("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("wr_mem_be", 32'(mem_be), 32'hF);
        @(posedge clk); #1 set_m1(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("wr_no_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'd0);

        // Continuous contention: m1 forced on cycle MAX_WAIT, m0 reads
        // return in between, m1 data one cycle after its grant.
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            set_m0(1'b1, 1'b0, 32'h30, 32'h0);
            set_m1(1'b1, 1'b0, 32'h40, 32'h0);
            @(negedge clk);
            check($sformatf("cont_m1_gnt[%0d]", c), 32'(m1_gnt), 32'(c == 8));
            check($sformatf("cont_m0_gnt[%0d]", c), 32'(m0_gnt), 32'(c != 8));
            check($sformatf("cont_starved[%0d]", c), 32'(m1_starved), 32'(c == 8));
            check($sformatf("cont_m1_rvalid[%0d]", c), 32'(m1_rvalid), 32'(c == 9));
            check($sformatf("cont_m0_rvalid[%0d]", c), 32'(m0_rvalid), 32'(c >= 1 && c <= 8));
        end
        @(posedge clk); #1;
        set_m0(1'b0, 1'b0, 32'h0, 32'h0);
        set_m1(1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);

        // Back-to-back m0 reads: one response per cycle, no bubbles.
        b2b_exp[0] = 32'h1111_0000;
        b2b_exp[1] = 32'h2222_0004;
        b2b_exp[2] = 32'h3333_0008;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (c < 3) set_m0(1'b1, 1'b0, 32'(4 * c), 32'h0);
            else       set_m0(1'b0, 1'b0, 32'h0, 32'h0);
            @(negedge clk);
            if (c > 0) begin
                check($sformatf("b2b_rvalid[%0d]", c), 32'(m0_rvalid), 32'd1);
                check($sformatf("b2b_rdata[%0d]", c), m0_rdata, b2b_exp[c-1]);
            end
        end

        // Reset mid-read: the granted m1 read must never answer.
        @(posedge clk); #1 set_m1(1'b1, 1'b0, 32'h44, 32'h0);
        @(negedge clk);
        check("rmr_m1_gnt", 32'(m1_gnt), 32'd1);
        #2 rst_n = 1'b0;
        @(posedge clk); #1 set_m1(1'b0, 1'b0, 32'h0, 32'h0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rmr_m1_rvalid", 32'(m1_rvalid), 32'd0);
        @(negedge clk);
        check("rmr_m1_rvalid_late", 32'(m1_rvalid), 32'd0);

        // Random traffic obeying hold-until-grant; m1 occasionally gives up.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk); #1;
            m0_rate = ((cyc / 200) % 2 == 1) ? 95 : 50;
            if (!(m0_req && !last_g0)) begin
                m0_req    = ($urandom_range(0, 99) < m0_rate);
                m0_we     = 1'($urandom_range(0, 1));
                m0_be     = 4'($urandom);
                m0_funct3 = 3'($urandom);
                m0_addr   = {24'd0, 6'($urandom), 2'b00};
                m0_wdata  = $urandom;
            end
            if (m1_req && !last_g1) begin
                if ($urandom_range(0, 99) < 3) m1_req = 1'b0;
            end else begin
                m1_req    = ($urandom_range(0, 99) < 40);
                m1_we     = 1'($urandom_range(0, 1));
                m1_be     = 4'($urandom);
                m1_funct3 = 3'($urandom);
                m1_addr   = {24'd0, 6'($urandom), 2'b00};
                m1_wdata  = $urandom;
            end
        end
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single-port DataMemory between the PipelinedCPU data port (m0) and a secondary master (m1, e.g. a UART program loader or debug DMA). It sits between the requesters and DataMemory. It grants at most one access per cycle, with fixed priority to the CPU and a starvation bound for m1. It also routes the one-cycle-latency read data back to whichever requester issued the read.

## Interface
- ALEN, 32, address width
- XLEN, 32, data width
- MAX_WAIT, 8, number of consecutive denied m1 cycles after which m1 wins over m0 (1..255)
- clk  in  1  system clock (cpu_clk domain)
- rst_n  in  1  reset, asynchronous and active-low
- m0_req / m1_req  in  1  access request; held with payload stable until the matching gnt
- m0_we / m1_we  in  1  write enable (0 = read)
- m0_be / m1_be  in  4  byte enables
- m0_funct3 / m1_funct3  in  3  load/store size code, passed to memory
- m0_addr / m1_addr  in  ALEN  byte address
- m0_wdata / m1_wdata  in  XLEN  write data
- m0_gnt / m1_gnt  out  1  combinational; request accepted this cycle
- m0_rvalid / m1_rvalid  out  1  read data valid for this requester
- m0_rdata / m1_rdata  out  XLEN  read data
- mem_we  out  1  to DataMemory MemWrite
- mem_be  out  4  to DataMemory be
- mem_funct3  out  3  to DataMemory funct3
- mem_addr  out  ALEN  to DataMemory Address
- mem_wdata  out  XLEN  to DataMemory WriteData
- mem_rdata  in  XLEN  from DataMemory ReadData; valid one cycle after the read is presented
- m1_starved  out  1  registered; high while wait_cnt == MAX_WAIT

## Operation
- Grant decision (combinational, per cycle):
  - force_m1 = m1_req && (wait_cnt == MAX_WAIT).
  - If force_m1: grant m1.
  - Else if m0_req: grant m0.
  - Else if m1_req: grant m1.
  - Else: no grant.
- Exactly one gnt is high when any req is high; both gnt are low when no req is high.
- Memory mux: mem_addr, mem_wdata, mem_be, mem_funct3 and mem_we follow the granted requester.
  - With no grant: mem_we = 0 and mem_be = 0; mem_addr, mem_wdata and mem_funct3 follow m0 (don't-care).
- Starvation counter wait_cnt (8 bits):
  - If m1_req && !m1_gnt: increment, saturating at MAX_WAIT.
  - If m1_gnt or !m1_req: clear to 0.
- Read tracking registers:
  - rd_pend (1 bit) and rd_owner (1 bit) capture a granted read (gnt && !we) each cycle.
  - Both clear on any cycle with no granted read.
- Response routing:
  - m{rd_owner}_rvalid = rd_pend; the other rvalid is 0.
  - Both m0_rdata and m1_rdata = mem_rdata (unqualified); requesters use their own rvalid.
- Writes produce no rvalid. Write completion is the gnt cycle.
- Back-to-back: a new grant may issue in the same cycle an earlier read's rvalid is high. The pipeline fully overlaps (1 access/cycle throughput).
- m1_starved is a registered copy of (next wait_cnt == MAX_WAIT).

## Timing
- Reset (rst_n low, asynchronous): wait_cnt = 0, rd_pend = 0, rd_owner = 0, m1_starved = 0, so both rvalid = 0.
  - Combinational outputs still follow inputs during reset. mem_we is forced to 0 while rst_n is low.
- Reset mid-read: a pending rvalid is dropped, never delivered after reset release.
- Read latency: grant in cycle N, rvalid and rdata in cycle N+1.
- Write: memory writes at the clk edge ending cycle N.
- Simultaneous m0_req and m1_req with wait_cnt < MAX_WAIT: m0 wins, m1 waits.
  - Continuous contention yields m1 a grant on the (MAX_WAIT+1)-th cycle.
  - m0 is then denied exactly one cycle.
- Requesters must not change payload while req && !gnt. A violation is not detected.
- m1 dropping req before grant clears wait_cnt. There is no credit carry-over.

## Test plan
- Reset: hold rst_n low, drive m0_req = 1 read -> mem_we = 0, both rvalid = 0, wait_cnt = 0. Release -> m0 read of 0x10 returns mem_rdata to m0 one cycle later with m0_rvalid = 1, m1_rvalid = 0.
- Single m1 write: m1_req = 1, we = 1, addr = 0x20, wdata = 0xDEADBEEF, be = 0xF, m0 idle -> m1_gnt the same cycle; memory shows the mem_ outputs equal to the m1 payload; no rvalid.
- Contention, MAX_WAIT = 8: m0 and m1 both request reads every cycle -> m0 granted cycles 0-7; m1_starved high after cycle 7; m1 granted in cycle 8; m0 granted again in cycle 9; m1_rvalid only in cycle 9.
- Back-to-back: m0 reads 0x0, 0x4, 0x8 on consecutive cycles -> three m0_rvalid pulses on consecutive cycles with the matching data, zero bubbles.
- Interleave: m0 read in cycle N, m1 forced read in cycle N+1 -> m0_rvalid in N+1, m1_rvalid in N+2, never both high.
- Reset mid-read: grant an m1 read, assert rst_n low before the next edge -> m1_rvalid stays 0 after release.
